fmap_arbiter: RTL and testbench

Feature-map memory responder: owns one IMG_WIDTH×IMG_HEIGHT feature-map RAM and serves the `arbiter_if` read and write ports driven by the convolution and pooling initiators (client 0 = conv, client 1 = pooling). It arbitrates requests round-robin, maps `vec2_t` coordinates to addresses, and returns registered read data. It also performs a sequential whole-map clear between timesteps.

---
 rtl/fmap_arbiter_pkg.sv | 48 ++++
 rtl/fmap_ram.sv | 35 +++
 rtl/fmap_arbiter.sv | 150 +++++++++++++++
 tb/tb_fmap_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmap_arbiter_pkg : shared types and helpers for the feature-map responder
// Revision: 1.0
// ---------------------------------------------------------------------------
package fmap_arbiter_pkg;

   localparam int DEFAULT_CHANNELS    = 4;
   localparam int DEFAULT_NEURON_BITS = 8;
   localparam int DEFAULT_IMG_WIDTH   = 8;
   localparam int DEFAULT_IMG_HEIGHT  = 4;
   localparam int COORD_BITS          = 8;
   localparam int FMAP_ADDR_BITS      = 16;

   typedef struct packed {
      logic [COORD_BITS-1:0] x;
      logic [COORD_BITS-1:0] y;
   } vec2_t;

   typedef logic                      client_id_t;
   typedef logic [FMAP_ADDR_BITS-1:0] fmap_addr_t;

   typedef struct packed {
      logic       valid;
      fmap_addr_t addr;
   } fmap_loc_t;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } fmap_state_t;

   function automatic fmap_loc_t coord_to_addr(vec2_t c, int unsigned w, int unsigned h);
      fmap_loc_t   r;
      int unsigned lin;
      lin     = 32'(c.y) * w + 32'(c.x);
      r.valid = (32'(c.x) < w) && (32'(c.y) < h) && (lin < 32'h0001_0000);
      r.addr  = lin[FMAP_ADDR_BITS-1:0];
      return r;
   endfunction

   // Contention goes to the client that was not served last.
   function automatic client_id_t rr_pick(logic [1:0] req, client_id_t last);
      return (&req) ? ~last : req[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmap_ram : simple dual-port RAM, write-first, one-cycle registered read
// Revision: 1.0
// ---------------------------------------------------------------------------
module fmap_ram #(
   parameter int W     = 32,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fmap_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmap_arbiter : two-client round-robin responder for the feature-map RAM
// Revision: 1.0
// ---------------------------------------------------------------------------
module fmap_arbiter
   import fmap_arbiter_pkg::*;
#(
   parameter int CHANNELS         = DEFAULT_CHANNELS,
   parameter int BITS_PER_CHANNEL = DEFAULT_NEURON_BITS,
   parameter int IMG_WIDTH        = DEFAULT_IMG_WIDTH,
   parameter int IMG_HEIGHT       = DEFAULT_IMG_HEIGHT
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [1:0]                                 rd_req,
   input  vec2_t [1:0]                                rd_coord,
   output logic [1:0]                                 rd_grant,
   output logic [1:0][CHANNELS*BITS_PER_CHANNEL-1:0]  rd_data,
   output logic [1:0]                                 rd_valid,
   input  logic [1:0]                                 wr_req,
   input  vec2_t [1:0]                                wr_coord,
   input  logic [1:0][CHANNELS*BITS_PER_CHANNEL-1:0]  wr_data,
   output logic [1:0]                                 wr_grant,
   input  logic                                       clear_start,
   output logic                                       busy,
   output logic                                       addr_err
);

   localparam int          W  = CHANNELS * BITS_PER_CHANNEL;
   localparam int unsigned N  = IMG_WIDTH * IMG_HEIGHT;
   localparam int          AW = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

   fmap_state_t       r_state;
   logic [AW-1:0]     r_clr_addr;
   client_id_t        r_rr_rd;
   client_id_t        r_rr_wr;
   logic [1:0]        r_rd_valid;
   logic              r_rd_zero;
   logic [1:0][W-1:0] r_rd_hold;
   logic              r_addr_err;

   logic              w_serve;
   logic              w_clearing;
   client_id_t        w_rd_sel;
   client_id_t        w_wr_sel;
   fmap_loc_t         w_rd_loc;
   fmap_loc_t         w_wr_loc;
   logic              w_rd_ok;
   logic              w_wr_ok;
   logic              w_ram_we;
   logic [AW-1:0]     w_ram_waddr;
   logic [W-1:0]      w_ram_wdata;
   logic [W-1:0]      w_ram_q;
   logic [W-1:0]      w_q_masked;

   // Reset also blocks grants and clear writes so an abort takes effect at once.
   assign w_serve    = (r_state == S_IDLE) && !reset;
   assign w_clearing = (r_state == S_CLEAR) && !reset;

   assign w_rd_sel = rr_pick(rd_req, r_rr_rd);
   assign w_wr_sel = rr_pick(wr_req, r_rr_wr);
   assign rd_grant = w_serve ? ((2'b01 << w_rd_sel) & rd_req) : 2'b00;
   assign wr_grant = w_serve ? ((2'b01 << w_wr_sel) & wr_req) : 2'b00;

   // The bound against N also keeps the slice to AW address bits honest.
   assign w_rd_loc = coord_to_addr(rd_coord[w_rd_sel], IMG_WIDTH, IMG_HEIGHT);
   assign w_wr_loc = coord_to_addr(wr_coord[w_wr_sel], IMG_WIDTH, IMG_HEIGHT);
   assign w_rd_ok  = w_rd_loc.valid && (32'(w_rd_loc.addr) < N);
   assign w_wr_ok  = w_wr_loc.valid && (32'(w_wr_loc.addr) < N);

   assign w_ram_we    = w_clearing || ((|wr_grant) && w_wr_ok);
   assign w_ram_waddr = w_clearing ? r_clr_addr : w_wr_loc.addr[AW-1:0];
   assign w_ram_wdata = w_clearing ? '0 : wr_data[w_wr_sel];

   fmap_ram #(
      .W     (W),
      .DEPTH (N),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_re    (|rd_grant),
      .i_raddr (w_rd_loc.addr[AW-1:0]),
      .o_rdata (w_ram_q)
   );

   assign w_q_masked = r_rd_zero ? '0 : w_ram_q;

   // A client sees the live RAM word on its valid cycle and its captured copy after.
   for (genvar c = 0; c < 2; c++) begin : g_client
      assign rd_data[c] = r_rd_valid[c] ? w_q_masked : r_rd_hold[c];
   end

   assign rd_valid = r_rd_valid;
   assign busy     = (r_state == S_CLEAR);
   assign addr_err = r_addr_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_clr_addr <= '0;
         r_rr_rd    <= 1'b1;
         r_rr_wr    <= 1'b1;
         r_rd_valid <= 2'b00;
         r_rd_zero  <= 1'b0;
         r_rd_hold  <= '0;
         r_addr_err <= 1'b0;
      end else begin
         r_rd_valid <= rd_grant;
         for (int c = 0; c < 2; c++) begin
            if (r_rd_valid[c]) begin
               r_rd_hold[c] <= w_q_masked;
            end
         end
         if (|rd_grant) begin
            r_rd_zero <= !w_rd_ok;
            r_rr_rd   <= w_rd_sel;
         end
         if (|wr_grant) begin
            r_rr_wr <= w_wr_sel;
         end
         if (((|rd_grant) && !w_rd_ok) || ((|wr_grant) && !w_wr_ok)) begin
            r_addr_err <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (clear_start) begin
                  r_state    <= S_CLEAR;
                  r_clr_addr <= '0;
               end
            end
            S_CLEAR: begin
               if (r_clr_addr == LAST_ADDR) begin
                  r_state    <= S_IDLE;
                  r_clr_addr <= '0;
               end else begin
                  r_clr_addr <= r_clr_addr + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fmap_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fmap_arbiter : scenario bench for fmap_arbiter with a behavioural map model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fmap_arbiter;
   import fmap_arbiter_pkg::*;

   localparam int W  = DEFAULT_CHANNELS * DEFAULT_NEURON_BITS;
   localparam int IW = DEFAULT_IMG_WIDTH;
   localparam int IH = DEFAULT_IMG_HEIGHT;
   localparam int N  = IW * IH;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        rd_req, rd_grant, rd_valid, wr_req, wr_grant;
   vec2_t [1:0]       rd_coord, wr_coord;
   logic [1:0][W-1:0] rd_data, wr_data;
   logic              clear_start, busy, addr_err;

   fmap_arbiter #(
      .CHANNELS         (DEFAULT_CHANNELS),
      .BITS_PER_CHANNEL (DEFAULT_NEURON_BITS),
      .IMG_WIDTH        (IW),
      .IMG_HEIGHT       (IH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rd_req      (rd_req),
      .rd_coord    (rd_coord),
      .rd_grant    (rd_grant),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .wr_req      (wr_req),
      .wr_coord    (wr_coord),
      .wr_data     (wr_data),
      .wr_grant    (wr_grant),
      .clear_start (clear_start),
      .busy        (busy),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: memory image, last-served client per port, clear countdown.
   logic [W-1:0]      m_mem [N];
   int                m_last_rd, m_last_wr, m_clr_left;
   logic              m_err;
   logic [1:0]        m_valid;
   logic [1:0][W-1:0] m_data;
   logic [1:0]        e_rdg, e_wrg;

   logic [1:0]        o_rdg, o_wrg, o_rv;
   logic [1:0][W-1:0] o_rd;
   logic              o_busy, o_err;

   function automatic vec2_t xy(int x, int y);
      vec2_t v;
      v.x = 8'(x);
      v.y = 8'(y);
      return v;
   endfunction

   function automatic int lin(vec2_t c);
      if (int'(c.x) >= IW || int'(c.y) >= IH) return -1;
      return int'(c.y) * IW + int'(c.x);
   endfunction

   function automatic int pick(logic [1:0] req, int last);
      if (req == 2'b11) return 1 - last;
      return req[1] ? 1 : 0;
   endfunction

   task automatic cycle(input logic [1:0] rq, input vec2_t rc0, input vec2_t rc1,
                        input logic [1:0] wq, input vec2_t wc0, input vec2_t wc1,
                        input logic [W-1:0] wd0, input logic [W-1:0] wd1, input logic clr);
      int rs, ws, ra, wa;
      logic [W-1:0] rv;
      ws = 0; wa = -1;
      rd_req = rq; rd_coord[0] = rc0; rd_coord[1] = rc1;
      wr_req = wq; wr_coord[0] = wc0; wr_coord[1] = wc1;
      wr_data[0] = wd0; wr_data[1] = wd1;
      clear_start = clr;
      #1;
      o_rdg = rd_grant;
      o_wrg = wr_grant;
      e_rdg = 2'b00;
      e_wrg = 2'b00;
      if (m_clr_left == 0) begin
         if (wq != 2'b00) begin
            ws = pick(wq, m_last_wr);
            m_last_wr = ws;
            e_wrg[ws] = 1'b1;
            wa = lin(ws == 0 ? wc0 : wc1);
            if (wa < 0) m_err = 1'b1;
         end
         if (rq != 2'b00) begin
            rs = pick(rq, m_last_rd);
            m_last_rd = rs;
            e_rdg[rs] = 1'b1;
            ra = lin(rs == 0 ? rc0 : rc1);
            if (ra < 0) begin
               rv = '0;
               m_err = 1'b1;
            end else if (wq != 2'b00 && wa == ra) begin
               rv = (ws == 0) ? wd0 : wd1;
            end else begin
               rv = m_mem[ra];
            end
            m_data[rs] = rv;
         end
         if (wq != 2'b00 && wa >= 0) m_mem[wa] = (ws == 0) ? wd0 : wd1;
         if (clr) m_clr_left = N;
      end else begin
         m_mem[N - m_clr_left] = '0;
         m_clr_left--;
      end
      m_valid = e_rdg;
      @(posedge clk);
      #1;
      o_rv = rd_valid; o_rd = rd_data; o_busy = busy; o_err = addr_err;
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(2'b00, xy(0, 0), xy(0, 0), 2'b00, xy(0, 0), xy(0, 0), '0, '0, 1'b0);
   endtask

   task automatic rd(input int c, input vec2_t p);
      cycle(c == 0 ? 2'b01 : 2'b10, p, p, 2'b00, xy(0, 0), xy(0, 0), '0, '0, 1'b0);
   endtask

   task automatic wr(input int c, input vec2_t p, input logic [W-1:0] d);
      cycle(2'b00, xy(0, 0), xy(0, 0), c == 0 ? 2'b01 : 2'b10, p, p, d, d, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rd_req = 2'b00; wr_req = 2'b00; clear_start = 1'b0;
      rd_coord = '0; wr_coord = '0; wr_data = '0;
      @(posedge clk);
      #1;
      m_clr_left = 0; m_last_rd = 1; m_last_wr = 1; m_err = 1'b0;
      m_valid = 2'b00; m_data = '0;
      o_rv = rd_valid; o_rd = rd_data; o_busy = busy; o_err = addr_err;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (o_rv !== 2'b00) begin miscompares++; $display("FAIL reset_rd_valid: got %b expected 00", o_rv); end
      vectors++;
      if (o_rd !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0", o_rd); end
      vectors++;
      if ({o_busy, o_err} !== 2'b00) begin miscompares++; $display("FAIL reset_busy_err: got %b expected 00", {o_busy, o_err}); end
   endtask

   task automatic test_fill();
      for (int a = 0; a < N; a++) begin
         wr(a % 2, xy(a % IW, a / IW), W'($urandom()));
         vectors++;
         if (o_wrg !== e_wrg) begin miscompares++; $display("FAIL fill_grant[%0d]: got %b expected %b", a, o_wrg, e_wrg); end
      end
   endtask

   task automatic test_write_read();
      wr(0, xy(3, 2), 32'hA5A5_A5A5);
      vectors++;
      if (o_wrg !== 2'b01) begin miscompares++; $display("FAIL wr_grant: got %b expected 01", o_wrg); end
      rd(1, xy(3, 2));
      vectors++;
      if (o_rdg !== 2'b10) begin miscompares++; $display("FAIL rd_grant: got %b expected 10", o_rdg); end
      vectors++;
      if (o_rv !== 2'b10 || o_rd[1] !== 32'hA5A5_A5A5) begin
         miscompares++;
         $display("FAIL wr_rd_data: got valid %b data %h expected 10 a5a5a5a5", o_rv, o_rd[1]);
      end
   endtask

   task automatic test_contention();
      logic [1:0] exp;
      for (int i = 0; i < 4; i++) begin
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
         cycle(2'b11, xy(i, 0), xy(i, 1), 2'b00, xy(0, 0), xy(0, 0), '0, '0, 1'b0);
         vectors++;
         if (o_rdg !== exp) begin miscompares++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, o_rdg, exp); end
         vectors++;
         if (o_rv !== exp || o_rd !== m_data) begin
            miscompares++;
            $display("FAIL contention_data[%0d]: got %b %h expected %b %h", i, o_rv, o_rd, exp, m_data);
         end
      end
   endtask

   task automatic test_bypass();
      cycle(2'b01, xy(5, 0), xy(0, 0), 2'b10, xy(0, 0), xy(5, 0), '0, 32'h3C3C_3C3C, 1'b0);
      vectors++;
      if ({o_rdg, o_wrg} !== 4'b0110) begin miscompares++; $display("FAIL bypass_grant: got %b expected 0110", {o_rdg, o_wrg}); end
      vectors++;
      if (o_rv !== 2'b01 || o_rd[0] !== 32'h3C3C_3C3C) begin
         miscompares++;
         $display("FAIL bypass_data: got %b %h expected 01 3c3c3c3c", o_rv, o_rd[0]);
      end
   endtask

   task automatic test_random();
      logic [1:0] rq, wq;
      for (int i = 0; i < 300; i++) begin
         rq = 2'($urandom());
         wq = 2'($urandom());
         cycle(rq, xy($urandom_range(3), $urandom_range(1)), xy($urandom_range(3), $urandom_range(1)),
               wq, xy($urandom_range(3), $urandom_range(1)), xy($urandom_range(3), $urandom_range(1)),
               W'($urandom()), W'($urandom()), 1'b0);
         vectors++;
         if ({o_rdg, o_wrg} !== {e_rdg, e_wrg}) begin
            miscompares++;
            $display("FAIL random_grant[%0d]: got %b expected %b", i, {o_rdg, o_wrg}, {e_rdg, e_wrg});
         end
         vectors++;
         if ({o_rv, o_rd, o_busy, o_err} !== {m_valid, m_data, 1'b0, m_err}) begin
            miscompares++;
            $display("FAIL random_out[%0d]: got %b %h %b%b expected %b %h 0%b", i, o_rv, o_rd, o_busy, o_err, m_valid, m_data, m_err);
         end
      end
   endtask

   task automatic test_clear();
      int   n;
      logic done, pb;
      n = 0;
      done = 1'b0;
      cycle(2'b01, xy(0, 0), xy(0, 0), 2'b00, xy(0, 0), xy(0, 0), '0, '0, 1'b1);
      vectors++;
      if (o_rdg !== 2'b01 || o_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL clear_start_cycle: got grant %b busy %b expected 01 1", o_rdg, o_busy);
      end
      for (int i = 0; i < 2 * N && !done; i++) begin
         pb = o_busy;
         cycle(2'b11, xy(2, 1), xy(6, 3), 2'b11, xy(1, 1), xy(1, 1), W'($urandom()), W'($urandom()), i == 3);
         vectors++;
         if (pb) begin
            n++;
            if ({o_rdg, o_wrg} !== 4'b0000) begin miscompares++; $display("FAIL clear_no_grant[%0d]: got %b expected 0000", i, {o_rdg, o_wrg}); end
         end else begin
            done = 1'b1;
            if ({o_rdg, o_wrg} !== {e_rdg, e_wrg}) begin
               miscompares++;
               $display("FAIL clear_exit_grant: got %b expected %b", {o_rdg, o_wrg}, {e_rdg, e_wrg});
            end
         end
      end
      vectors++;
      if (n !== N || !done) begin miscompares++; $display("FAIL clear_busy_len: got %0d cycles expected %0d", n, N); end
      rd(0, xy(0, 0));
      vectors++;
      if (o_rv !== 2'b01 || o_rd[0] !== '0) begin miscompares++; $display("FAIL clear_word0: got %b %h expected 01 0", o_rv, o_rd[0]); end
      rd(1, xy(IW - 1, IH - 1));
      vectors++;
      if (o_rv !== 2'b10 || o_rd[1] !== '0) begin miscompares++; $display("FAIL clear_wordlast: got %b %h expected 10 0", o_rv, o_rd[1]); end
   endtask

   task automatic test_range();
      rd(0, xy(IW, 0));
      vectors++;
      if (o_rdg !== 2'b01) begin miscompares++; $display("FAIL range_rd_grant: got %b expected 01", o_rdg); end
      vectors++;
      if (o_rd[0] !== '0 || o_err !== 1'b1) begin miscompares++; $display("FAIL range_rd: got %h err %b expected 0 err 1", o_rd[0], o_err); end
      idle();
      idle();
      idle();
      vectors++;
      if (o_err !== 1'b1) begin miscompares++; $display("FAIL range_err_sticky: got %b expected 1", o_err); end
      wr(1, xy(0, IH), 32'hFFFF_FFFF);
      vectors++;
      if (o_wrg !== 2'b10) begin miscompares++; $display("FAIL range_wr_grant: got %b expected 10", o_wrg); end
      for (int a = 0; a < N; a++) begin
         rd(a % 2, xy(a % IW, a / IW));
         vectors++;
         if (o_rv !== m_valid || o_rd !== m_data) begin
            miscompares++;
            $display("FAIL range_scan[%0d]: got %b %h expected %b %h", a, o_rv, o_rd, m_valid, m_data);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      wr(0, xy(0, 0), 32'h1111_1111);
      wr(1, xy(IW - 1, IH - 1), 32'h2222_2222);
      cycle(2'b00, xy(0, 0), xy(0, 0), 2'b00, xy(0, 0), xy(0, 0), '0, '0, 1'b1);
      for (int i = 0; i < N / 2; i++) idle();
      vectors++;
      if (o_busy !== 1'b1) begin miscompares++; $display("FAIL midclear_busy: got %b expected 1", o_busy); end
      do_reset();
      vectors++;
      if (o_busy !== 1'b0 || o_err !== 1'b0) begin miscompares++; $display("FAIL midclear_reset: got busy %b err %b expected 0 0", o_busy, o_err); end
      rd(0, xy(0, 0));
      vectors++;
      if (o_rd[0] !== '0) begin miscompares++; $display("FAIL midclear_word0: got %h expected 0", o_rd[0]); end
      rd(1, xy(IW - 1, IH - 1));
      vectors++;
      if (o_rd[1] !== 32'h2222_2222) begin miscompares++; $display("FAIL midclear_wordlast: got %h expected 22222222", o_rd[1]); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_write_read();
      test_contention();
      test_bypass();
      test_random();
      test_clear();
      test_range();
      test_reset_mid_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
